// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, one outstanding fetch, valid/ready to the core.
// Optional IFU_ALIGN_CHECK_EN: misaligned PCs raise a fetch fault instead of a request.
module ysyx_23060096_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   input  logic        resp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic        r_fault;
   logic        r_kill;
   logic        r_halt_pend;
   logic        w_halt;
   logic        w_misalign;
   logic        w_req_fire;

`ifdef IFU_ALIGN_CHECK_EN
   assign w_misalign = |r_pc[1:0];
`else
   assign w_misalign = 1'b0;
`endif

   assign w_halt     = halt | r_halt_pend;
   assign w_req_fire = (r_state == S_REQ) & ~w_misalign & req_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_REQ: begin
            if (w_req_fire)
               w_next = S_WAIT;
            else if (w_halt)
               w_next = S_HALT;
            else if (!redirect_valid && w_misalign)
               w_next = S_HOLD;
         end
         S_WAIT: begin
            // A killed or halting fetch still has to be drained.
            if (resp_valid) begin
               if (w_halt)
                  w_next = S_HALT;
               else if (redirect_valid || r_kill)
                  w_next = S_REQ;
               else
                  w_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_halt)
               w_next = S_HALT;
            else if (redirect_valid || inst_ready)
               w_next = S_REQ;
         end
         S_HALT: w_next = S_HALT;
         default: w_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc        <= RESET_PC;
         r_inst      <= 32'h0;
         r_inst_pc   <= 32'h0;
         r_fault     <= 1'b0;
         r_kill      <= 1'b0;
         r_halt_pend <= 1'b0;
      end else begin
         r_halt_pend <= w_halt;
         unique case (r_state)
            S_REQ: begin
               if (redirect_valid) begin
                  r_pc   <= redirect_pc;
                  r_kill <= w_req_fire;
               end else if (w_next == S_HOLD) begin
                  r_inst    <= 32'h0;
                  r_inst_pc <= r_pc;
                  r_fault   <= 1'b1;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  r_pc   <= redirect_pc;
                  r_kill <= ~resp_valid;
               end else if (resp_valid) begin
                  r_kill <= 1'b0;
                  if (w_next == S_HOLD) begin
                     r_inst    <= resp_data;
                     r_inst_pc <= r_pc;
                     r_fault   <= resp_err;
                  end
               end
            end
            S_HOLD: begin
               if (redirect_valid)
                  r_pc <= redirect_pc;
               else if (!w_halt && inst_ready)
                  r_pc <= r_pc + PC_STEP;
            end
            S_HALT: ;
            default: ;
         endcase
      end
   end

   always_comb begin
      req_valid  = rstn & (r_state == S_REQ) & ~w_misalign;
      req_addr   = r_pc;
      inst_valid = (r_state == S_HOLD);
      inst       = r_inst;
      inst_pc    = r_inst_pc;
      inst_fault = r_fault;
      halted     = (r_state == S_HALT);
   end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Directed cycle-vector bench for ysyx_23060096_ifu.
// Rows: inputs driven for one cycle plus the outputs expected in that cycle.
module tb_ysyx_23060096_ifu;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        halted;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_23060096_ifu dut (
      .clk            (clk),
      .rstn           (rstn),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .resp_err       (resp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halted         (halted)
   );

   typedef struct {
      logic        rdy;
      logic        rsv;
      logic [31:0] rdata;
      logic        rerr;
      logic        irdy;
      logic        rdv;
      logic [31:0] rdpc;
      logic        hlt;
      logic        rv;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] inst;
      logic [31:0] ipc;
      logic        flt;
      logic        hd;
   } vec_t;

   vec_t tv_a[$];
   vec_t tv_b[$];

   function automatic vec_t mk(
      logic rdy, logic rsv, logic [31:0] rdata, logic rerr,
      logic irdy, logic rdv, logic [31:0] rdpc, logic hlt,
      logic rv, logic [31:0] addr, logic iv, logic [31:0] ins,
      logic [31:0] ipc, logic flt, logic hd);
      vec_t v;
      v.rdy = rdy; v.rsv = rsv; v.rdata = rdata; v.rerr = rerr;
      v.irdy = irdy; v.rdv = rdv; v.rdpc = rdpc; v.hlt = hlt;
      v.rv = rv; v.addr = addr; v.iv = iv; v.inst = ins;
      v.ipc = ipc; v.flt = flt; v.hd = hd;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endtask

   task automatic idle_in();
      req_ready = 0; resp_valid = 0; resp_data = 0; resp_err = 0;
      inst_ready = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
   endtask

   // Called at a negedge; leaves at the next negedge with rstn released.
   task automatic do_reset();
      idle_in();
      rstn = 1'b0;
      #1;
      chk("rst_req_valid", {31'b0, req_valid}, 0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_inst_fault", {31'b0, inst_fault}, 0);
      chk("rst_halted", {31'b0, halted}, 0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic step(input vec_t v, input string tag);
      req_ready = v.rdy; resp_valid = v.rsv; resp_data = v.rdata;
      resp_err = v.rerr; inst_ready = v.irdy; redirect_valid = v.rdv;
      redirect_pc = v.rdpc; halt = v.hlt;
      #1;
      chk({tag, ".req_valid"}, {31'b0, req_valid}, {31'b0, v.rv});
      chk({tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, v.iv});
      chk({tag, ".halted"}, {31'b0, halted}, {31'b0, v.hd});
      if (v.rv) chk({tag, ".req_addr"}, req_addr, v.addr);
      if (v.iv) begin
         chk({tag, ".inst"}, inst, v.inst);
         chk({tag, ".inst_pc"}, inst_pc, v.ipc);
         chk({tag, ".inst_fault"}, {31'b0, inst_fault}, {31'b0, v.flt});
      end
      @(negedge clk);
   endtask

   initial begin
      // basic fetch, stall, HOLD redirect, WAIT redirect, error, halt in WAIT
      tv_a.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0000,0,0,0,0,0));
      tv_a.push_back(mk(0,1,32'h0010_0093,0, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(0,0,0,0, 1,0,0,0,
                        0,0,1,32'h0010_0093,32'h8000_0000,0,0));
      tv_a.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0004,0,0,0,0,0));
      tv_a.push_back(mk(0,1,32'h0020_0113,0, 0,0,0,0, 0,0,0,0,0,0,0));
      for (int k = 0; k < 5; k++)
         tv_a.push_back(mk(1,1,32'h1111_1111,0, 0,0,0,0,
                           0,0,1,32'h0020_0113,32'h8000_0004,0,0));
      tv_a.push_back(mk(0,0,0,0, 1,0,0,0,
                        0,0,1,32'h0020_0113,32'h8000_0004,0,0));
      tv_a.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h8000_0008,0,0,0,0,0));
      tv_a.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0008,0,0,0,0,0));
      tv_a.push_back(mk(0,1,32'h0030_0193,0, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(0,0,0,0, 1,1,32'h8000_0040,0,
                        0,0,1,32'h0030_0193,32'h8000_0008,0,0));
      tv_a.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0040,0,0,0,0,0));
      tv_a.push_back(mk(0,0,0,0, 0,1,32'h8000_0100,0, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(0,1,32'hDEAD_BEEF,0, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0100,0,0,0,0,0));
      tv_a.push_back(mk(0,1,32'h0000_0013,1, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(0,0,0,0, 1,0,0,0,
                        0,0,1,32'h0000_0013,32'h8000_0100,1,0));
      tv_a.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0104,0,0,0,0,0));
      tv_a.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(0,1,32'h1234_5678,0, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_a.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,1));

      // after reset: REQ redirect+accept kill, 32-bit PC wrap, halt from REQ
      tv_b.push_back(mk(1,0,0,0, 0,1,32'h8000_0200,0,
                        1,32'h8000_0000,0,0,0,0,0));
      tv_b.push_back(mk(0,1,32'hDEAD_BEEF,0, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_b.push_back(mk(0,0,0,0, 0,1,32'hFFFF_FFFC,0,
                        1,32'h8000_0200,0,0,0,0,0));
      tv_b.push_back(mk(1,0,0,0, 0,0,0,0, 1,32'hFFFF_FFFC,0,0,0,0,0));
      tv_b.push_back(mk(0,1,32'hAAAA_5555,0, 0,0,0,0, 0,0,0,0,0,0,0));
      tv_b.push_back(mk(0,0,0,0, 1,0,0,0,
                        0,0,1,32'hAAAA_5555,32'hFFFF_FFFC,0,0));
      tv_b.push_back(mk(0,0,0,0, 0,0,0,1, 1,32'h0000_0000,0,0,0,0,0));
      tv_b.push_back(mk(1,1,32'h5555_AAAA,0, 1,1,32'h8000_0000,0,
                        0,0,0,0,0,0,1));

      idle_in();
      rstn = 1'b0;
      @(negedge clk);
      do_reset();
      foreach (tv_a[i]) step(tv_a[i], $sformatf("a%0d", i));

      for (int c = 0; c < 20; c++) begin
         req_ready = 1'($urandom);
         resp_valid = 1'($urandom);
         resp_data = $urandom;
         inst_ready = 1'($urandom);
         redirect_valid = 1'($urandom);
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         #1;
         chk("halt_req_valid", {31'b0, req_valid}, 0);
         chk("halt_inst_valid", {31'b0, inst_valid}, 0);
         chk("halt_halted", {31'b0, halted}, 1);
         @(negedge clk);
      end

      do_reset();
      foreach (tv_b[i]) step(tv_b[i], $sformatf("b%0d", i));

      do_reset();
      step(mk(0,0,0,0, 0,1,32'h8000_0002,0, 1,32'h8000_0000,0,0,0,0,0),
           "al0");
`ifdef IFU_ALIGN_CHECK_EN
      step(mk(1,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0), "al1");
      step(mk(0,0,0,0, 0,0,0,0, 0,0,1,32'h0,32'h8000_0002,1,0), "al2");
`else
      step(mk(1,0,0,0, 0,0,0,0, 1,32'h8000_0002,0,0,0,0,0), "al1");
      step(mk(0,1,32'h0000_0013,0, 0,0,0,0, 0,0,0,0,0,0,0), "al2");
      step(mk(0,0,0,0, 0,0,0,0, 0,0,1,32'h13,32'h8000_0002,0,0), "al3");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_23060096_ifu.md
Name: ysyx_23060096_ifu

Overview:
Instruction fetch unit directly upstream of the single-cycle core.
- Owns the architectural PC and issues one fetch request at a time over a valid/ready memory port.
- Captures the returned word and presents it with its PC to the core over a valid/ready handshake.
- Accepts branch/jump redirects from the core and a halt request raised by ebreak.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; first fetch address.
PC_STEP, 4, increment applied to the PC after each instruction is accepted.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rstn  input  1  asynchronous, active-low reset.
req_valid  output  1  fetch request valid.
req_ready  input  1  memory accepts the request.
req_addr  output  32  fetch address; equals the PC while req_valid is high.
resp_valid  input  1  fetch response valid; exactly one response per accepted request.
resp_data  input  32  fetched instruction word.
resp_err  input  1  bus error on this response.
inst_valid  output  1  inst/inst_pc hold a valid instruction.
inst_ready  input  1  core consumes the instruction.
inst  output  32  instruction word to the core.
inst_pc  output  32  PC of inst.
inst_fault  output  1  qualifies inst: fetch fault; valid only with inst_valid.
redirect_valid  input  1  core requests a new PC (taken branch or jump).
redirect_pc  input  32  redirect target.
halt  input  1  stop fetching (ebreak).
halted  output  1  IFU is in HALT.

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC, state=REQ, req_valid=0 while in reset, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, halted=0, kill=0.
- States: REQ, WAIT, HOLD, HALT.
- REQ: req_valid=1, req_addr=pc.
  - req_valid&&req_ready → WAIT.
  - Unaccepted requests keep req_addr stable unless a redirect occurs.
- WAIT: req_valid=0.
  - On resp_valid with kill=0: inst<=resp_data, inst_pc<=pc, inst_fault<=resp_err → HOLD.
  - On resp_valid with kill=1: discard the response, clear kill → REQ (or HALT if halt is pending).
- HOLD: inst_valid=1; inst, inst_pc and inst_fault stable until the handshake.
  - inst_valid&&inst_ready → pc<=pc+PC_STEP (32-bit wrap, 32'hFFFF_FFFC→0) → REQ.
- Latency: request accepted at edge N with response at edge N+k → inst_valid high from cycle N+k+1. Minimum fetch-to-accept is 3 cycles per instruction.
- Redirect has priority over the handshake completing in the same cycle:
  - In REQ: pc<=redirect_pc, request re-issued next cycle at the new address. If req_ready is also high this cycle, the request is accepted and kill<=1.
  - In WAIT: pc<=redirect_pc, kill<=1. If resp_valid arrives the same cycle, it is discarded → REQ.
  - In HOLD: drop the held instruction (no handshake even if inst_ready=1), pc<=redirect_pc → REQ.
  - In HALT: ignored.
- Halt (sampled every cycle, takes effect after redirect; sticky once seen):
  - From REQ without acceptance → HALT.
  - From WAIT → drain the outstanding response (discarded) → HALT.
  - From HOLD → HALT; the held instruction is dropped.
- HALT: req_valid=0, inst_valid=0, halted=1. Exit only through reset.
- Never more than one outstanding request. resp_valid outside WAIT is ignored.

Optional Feature:
IFU_ALIGN_CHECK_EN.
- Defined: a PC with pc[1:0]!=0 in REQ issues no memory request. Next cycle the IFU enters HOLD with inst=32'h0000_0000, inst_pc=pc, inst_fault=1.
- Not defined: low PC bits are passed through to req_addr unchecked. inst_fault reflects only resp_err.

Test Plan:
- Reset release, req_ready=1, resp 1 cycle later with 32'h0010_0093, inst_ready=1 → req_addr=0x8000_0000; inst_valid with inst=0x0010_0093, inst_pc=0x8000_0000; next req_addr=0x8000_0004.
- inst_ready=0 for 5 cycles in HOLD → inst and inst_pc stable, no new request; on inst_ready=1, exactly one PC increment.
- redirect_valid with redirect_pc=0x8000_0100 while in WAIT; stale response 0xDEAD_BEEF arrives → 0xDEAD_BEEF never presented; next req_addr=0x8000_0100.
- redirect and inst_ready both high in HOLD at pc=0x8000_0008, redirect_pc=0x8000_0040 → no handshake; next req_addr=0x8000_0040.
- halt asserted in WAIT → response drained, halted=1, req_valid stays 0 for 20 cycles; rstn pulse → req_addr=0x8000_0000.
- resp_err=1 → inst_fault=1 with inst_valid. With IFU_ALIGN_CHECK_EN, redirect_pc=0x8000_0002 → no request, inst_fault=1, inst_pc=0x8000_0002.
